// File: rtl/branch_resolve_unit.sv
// Execute-stage branch resolution: turns condition flags plus funct3 into a
// taken decision, checks it against the fetch prediction, issues a registered
// redirect with a multi-cycle flush, owns the 2-bit predictor table read by
// fetch, and keeps saturating performance counters.
module branch_resolve_unit #(
  parameter int IDX_BITS     = 4,
  parameter int FLUSH_CYCLES = 2
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic        ex_valid,
  input  logic [1:0]  ex_kind,
  input  logic [2:0]  ex_funct3,
  input  logic        br_eq,
  input  logic        br_lt,
  input  logic        br_ltu,
  input  logic [31:0] ex_pc,
  input  logic [31:0] ex_target,
  input  logic        ex_pred_taken,
  input  logic [31:0] fetch_pc,
  output logic        fetch_pred_taken,
  output logic        redirect_valid,
  output logic [31:0] redirect_pc,
  output logic        flush,
  output logic        illegal_br,
  output logic [31:0] br_count,
  output logic [31:0] mispred_count
);

  localparam int unsigned ENTRIES = 1 << IDX_BITS;

  typedef enum logic {
    IDLE,
    FLUSH
  } state_t;

  state_t      state, state_nx;
  logic [2:0]  fcnt, fcnt_nx;

  logic [1:0]  pht [ENTRIES];

  logic                sample;
  logic                is_br;
  logic                f3_illegal;
  logic                legal;
  logic                cond_taken;
  logic                actual_taken;
  logic                mispred;
  logic                redirect_req;
  logic                pht_update;
  logic [31:0]         next_pc;
  logic [IDX_BITS-1:0] ex_idx;
  logic [IDX_BITS-1:0] fetch_idx;
  logic                unused_fetch_pc_bits;

  assign ex_idx    = ex_pc[IDX_BITS+1:2];
  assign fetch_idx = fetch_pc[IDX_BITS+1:2];
  assign unused_fetch_pc_bits = ^{fetch_pc[31:IDX_BITS+2], fetch_pc[1:0]};

  // Fetch reads the pre-update entry; a same-cycle write lands next cycle.
  assign fetch_pred_taken = pht[fetch_idx][1];

  assign flush = (state == FLUSH);

  // Resolve the control transfer and decide whether fetch went the wrong way.
  always_comb begin
    sample     = (state == IDLE) && ex_valid && (ex_kind != 2'b00);
    is_br      = (ex_kind == 2'b01);
    f3_illegal = (ex_funct3[2:1] == 2'b01);
    legal      = !(is_br && f3_illegal);

    cond_taken = 1'b0;
    case (ex_funct3)
      3'b000:  cond_taken = br_eq;
      3'b001:  cond_taken = !br_eq;
      3'b100:  cond_taken = br_lt;
      3'b101:  cond_taken = !br_lt;
      3'b110:  cond_taken = br_ltu;
      3'b111:  cond_taken = !br_ltu;
      default: cond_taken = 1'b0;
    endcase

    actual_taken = is_br ? cond_taken : 1'b1;
    // JALR always redirects since fetch never knows its target.
    mispred      = legal && ((ex_kind == 2'b11) || (actual_taken != ex_pred_taken));
    redirect_req = sample && mispred;
    pht_update   = sample && is_br && !f3_illegal;
    next_pc      = actual_taken ? ex_target : (ex_pc + 32'd4);
  end

  // State and flush-counter register.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state <= IDLE;
      fcnt  <= '0;
    end else begin
      state <= state_nx;
      fcnt  <= fcnt_nx;
    end
  end

  // Next-state: hold FLUSH for FLUSH_CYCLES cycles after each redirect.
  always_comb begin
    state_nx = state;
    fcnt_nx  = fcnt;
    case (state)
      IDLE: begin
        if (redirect_req) begin
          state_nx = FLUSH;
          fcnt_nx  = 3'(FLUSH_CYCLES);
        end
      end
      FLUSH: begin
        if (fcnt <= 3'd1) begin
          state_nx = IDLE;
          fcnt_nx  = '0;
        end else begin
          fcnt_nx = fcnt - 3'd1;
        end
      end
      default: begin
        state_nx = IDLE;
        fcnt_nx  = '0;
      end
    endcase
  end

  // Registered redirect and illegal-funct3 pulses.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      redirect_valid <= 1'b0;
      redirect_pc    <= '0;
      illegal_br     <= 1'b0;
    end else begin
      redirect_valid <= redirect_req;
      if (redirect_req) begin
        redirect_pc <= next_pc;
      end
      illegal_br <= sample && is_br && f3_illegal;
    end
  end

  // Saturating performance counters.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      br_count      <= '0;
      mispred_count <= '0;
    end else begin
      if (sample && legal && (br_count != '1)) begin
        br_count <= br_count + 32'd1;
      end
      if (redirect_req && (mispred_count != '1)) begin
        mispred_count <= mispred_count + 32'd1;
      end
    end
  end

  // 2-bit saturating predictor table, trained by legal conditional branches only.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      for (int unsigned i = 0; i < ENTRIES; i++) begin
        pht[i] <= 2'b01;
      end
    end else if (pht_update) begin
      if (actual_taken) begin
        if (pht[ex_idx] != 2'b11) begin
          pht[ex_idx] <= pht[ex_idx] + 2'b01;
        end
      end else begin
        if (pht[ex_idx] != 2'b00) begin
          pht[ex_idx] <= pht[ex_idx] - 2'b01;
        end
      end
    end
  end

endmodule

// File: tb/tb_branch_resolve_unit.sv
// Directed bench for branch_resolve_unit with hand-computed expectations.
module tb_branch_resolve_unit;

  logic        CLK;
  logic        RST;
  logic        ex_valid;
  logic [1:0]  ex_kind;
  logic [2:0]  ex_funct3;
  logic        br_eq;
  logic        br_lt;
  logic        br_ltu;
  logic [31:0] ex_pc;
  logic [31:0] ex_target;
  logic        ex_pred_taken;
  logic [31:0] fetch_pc;
  logic        fetch_pred_taken;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        flush;
  logic        illegal_br;
  logic [31:0] br_count;
  logic [31:0] mispred_count;

  int errors = 0;
  int checks = 0;

  branch_resolve_unit #(
    .IDX_BITS    (4),
    .FLUSH_CYCLES(2)
  ) dut (
    .CLK             (CLK),
    .RST             (RST),
    .ex_valid        (ex_valid),
    .ex_kind         (ex_kind),
    .ex_funct3       (ex_funct3),
    .br_eq           (br_eq),
    .br_lt           (br_lt),
    .br_ltu          (br_ltu),
    .ex_pc           (ex_pc),
    .ex_target       (ex_target),
    .ex_pred_taken   (ex_pred_taken),
    .fetch_pc        (fetch_pc),
    .fetch_pred_taken(fetch_pred_taken),
    .redirect_valid  (redirect_valid),
    .redirect_pc     (redirect_pc),
    .flush           (flush),
    .illegal_br      (illegal_br),
    .br_count        (br_count),
    .mispred_count   (mispred_count)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic peek(input string tag, input logic [31:0] addr, input logic exp);
    fetch_pc = addr;
    #1;
    check(tag, {31'd0, fetch_pred_taken}, {31'd0, exp});
  endtask

  task automatic drive(input logic [1:0] kind, input logic [2:0] f3,
                       input logic eq, input logic lt, input logic ltu,
                       input logic [31:0] pc, input logic [31:0] tgt, input logic pred);
    ex_valid      = 1'b1;
    ex_kind       = kind;
    ex_funct3     = f3;
    br_eq         = eq;
    br_lt         = lt;
    br_ltu        = ltu;
    ex_pc         = pc;
    ex_target     = tgt;
    ex_pred_taken = pred;
  endtask

  task automatic idle_in();
    ex_valid = 1'b0;
    ex_kind  = 2'b00;
  endtask

  task automatic outs(input string tag, input logic rv, input logic fl, input logic ill,
                      input logic [31:0] bc, input logic [31:0] mc);
    check({tag, ".rv"},  {31'd0, redirect_valid}, {31'd0, rv});
    check({tag, ".fl"},  {31'd0, flush},          {31'd0, fl});
    check({tag, ".ill"}, {31'd0, illegal_br},     {31'd0, ill});
    check({tag, ".bc"},  br_count,                bc);
    check({tag, ".mc"},  mispred_count,           mc);
  endtask

  initial begin
    RST = 1'b1;
    idle_in();
    ex_funct3 = '0; br_eq = 0; br_lt = 0; br_ltu = 0;
    ex_pc = '0; ex_target = '0; ex_pred_taken = 0; fetch_pc = '0;
    tick(); tick();

    // Reset state
    outs("rst", 0, 0, 0, 0, 0);
    check("rst.rpc", redirect_pc, 32'h0);
    peek("rst.p100", 32'h100, 1'b0);
    peek("rst.p10", 32'h10, 1'b0);
    RST = 1'b0;
    tick();

    // BEQ taken, predicted not taken: redirect to target, 2-cycle flush
    drive(2'b01, 3'b000, 1, 0, 0, 32'h100, 32'h140, 0);
    peek("beq.same_cycle_old", 32'h100, 1'b0);
    tick();
    idle_in();
    outs("beq.c1", 1, 1, 0, 1, 1);
    check("beq.rpc", redirect_pc, 32'h140);
    peek("beq.p100", 32'h100, 1'b1);
    tick();
    outs("beq.c2", 0, 1, 0, 1, 1);
    tick();
    outs("beq.c3", 0, 0, 0, 1, 1);

    // BGEU with ltu=1 is not taken, predicted taken: redirect to pc+4
    drive(2'b01, 3'b111, 0, 0, 1, 32'h200, 32'h280, 1);
    tick();
    outs("bgeu.c1", 1, 1, 0, 2, 2);
    check("bgeu.rpc", redirect_pc, 32'h204);
    peek("bgeu.p200", 32'h200, 1'b0);
    // A JALR offered during flush must be ignored entirely
    drive(2'b11, 3'b000, 0, 0, 0, 32'h600, 32'h700, 1);
    tick();
    outs("bgeu.c2", 0, 1, 0, 2, 2);
    tick();
    idle_in();
    outs("bgeu.c3", 0, 0, 0, 2, 2);
    check("bgeu.rpc_hold", redirect_pc, 32'h204);

    // Four back-to-back correctly predicted taken BLTs at 0x10
    for (int i = 0; i < 4; i++) begin
      drive(2'b01, 3'b100, 0, 1, 0, 32'h10, 32'h80, 1);
      tick();
      check($sformatf("blt%0d.rv", i), {31'd0, redirect_valid}, 32'd0);
      check($sformatf("blt%0d.fl", i), {31'd0, flush}, 32'd0);
    end
    idle_in();
    check("blt.bc", br_count, 32'd6);
    check("blt.mc", mispred_count, 32'd2);
    peek("blt.p10", 32'h10, 1'b1);

    // funct3=010 is illegal: pulse, no count, no training
    drive(2'b01, 3'b010, 1, 1, 1, 32'h10, 32'h90, 0);
    tick();
    idle_in();
    outs("ill.c1", 0, 0, 1, 6, 2);
    tick();
    outs("ill.c2", 0, 0, 0, 6, 2);

    // Saturation at 11: two not-taken BGEs (lt=1) step 11->10->01
    drive(2'b01, 3'b101, 0, 1, 0, 32'h10, 32'h90, 0);
    tick();
    peek("sat.p10_a", 32'h10, 1'b1);
    drive(2'b01, 3'b101, 0, 1, 0, 32'h10, 32'h90, 0);
    tick();
    idle_in();
    peek("sat.p10_b", 32'h10, 1'b0);
    outs("sat", 0, 0, 0, 8, 2);

    // JAL predicted taken: no redirect, counted
    drive(2'b10, 3'b000, 0, 0, 0, 32'h400, 32'h500, 1);
    tick();
    idle_in();
    outs("jal", 0, 0, 0, 9, 2);

    // JALR always redirects; reset in second flush cycle clears everything
    drive(2'b11, 3'b000, 0, 0, 0, 32'h404, 32'h3000, 1);
    tick();
    idle_in();
    outs("jalr.c1", 1, 1, 0, 10, 3);
    check("jalr.rpc", redirect_pc, 32'h3000);
    tick();
    check("jalr.c2.fl", {31'd0, flush}, 32'd1);
    #2;
    RST = 1'b1;
    #1;
    outs("arst", 0, 0, 0, 0, 0);
    check("arst.rpc", redirect_pc, 32'h0);
    peek("arst.p100", 32'h100, 1'b0);
    tick();
    RST = 1'b0;
    tick();
    outs("post", 0, 0, 0, 0, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
